// File: rtl/sine_lut.sv
// -----------------------------------------------------------------------------
// sine_lut
//   Quarter-wave sine lookup for the correlator DDS datapath. A phase index v
//   covering one quadrant [0, pi/2) selects a positive amplitude
//     sv = round_half_up(AMPL * sin(pi * v / 2**(ADDR_W+1)))
//   The caller handles quadrant folding: it inverts the index for quadrants 1
//   and 3 and negates the amplitude for quadrants 2 and 3.
//
//   The table contents are computed at elaboration time by an integer-only
//   constant function, using Q60 fixed point and a Taylor series. No real
//   arithmetic exists in hardware. The result is a constant 2**ADDR_W-entry
//   table (ROM/LUTs) that feeds a single output register.
//
// Ports
//   clk  in   1       system clock, rising edge
//   rst  in   1       synchronous, active-high reset (priority over lookup)
//   v    in   ADDR_W  quarter-wave phase index, one new value per cycle
//   sv   out  DATA_W  registered amplitude, 1 cycle latency, MSB always 0
// -----------------------------------------------------------------------------
module sine_lut #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMPL   = 32767
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] v,
  output logic [DATA_W-1:0] sv
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Fixed-point precision of the build-time sine evaluation. Pi is taken from
  // its hexadecimal expansion 3.243F6A8885A308D..., so it needs no rounding.
  localparam int unsigned  FRAC   = 60;
  localparam logic [127:0] PI_Q60 = 128'h3243_F6A8_885A_308D;
  // The Taylor series of sin(x) for x < pi/2 drops below 2**-60 before the
  // x**25 term, so 12 correction terms after x are sufficient.
  localparam int unsigned  TERMS  = 12;

  // Exact table entry for one phase index, built from integers only.
  // Intermediate values stay below 2**123, so 128-bit math cannot overflow.
  function automatic logic [DATA_W-1:0] sine_entry(input logic [ADDR_W-1:0] idx);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] pos;
    logic [127:0] neg;
    logic [127:0] y;
    // Angle in Q60: pi * idx / 2**(ADDR_W+1).
    x    = (PI_Q60 * 128'(idx)) >> (ADDR_W + 1);
    x2   = (x * x) >> FRAC;
    term = x;
    pos  = x;
    neg  = '0;
    // Each term is the previous one times x^2 / ((2k)(2k+1)). The signs
    // alternate, so positive and negative terms are summed separately and
    // stay unsigned.
    for (int k = 1; k <= int'(TERMS); k++) begin
      term = ((term * x2) >> FRAC) / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) neg = neg + term;
      else              pos = pos + term;
    end
    // Scale to amplitude and round half up. The accumulated truncation error
    // is far below one LSB, so the result matches the exact value.
    y = 128'(AMPL) * (pos - neg);
    y = (y + (128'd1 << (FRAC - 1))) >> FRAC;
    return y[DATA_W-1:0];
  endfunction

  // Constant table; each entry is resolved at elaboration.
  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    localparam logic [DATA_W-1:0] ENTRY = sine_entry(ADDR_W'(i));
    assign rom[i] = ENTRY;
  end

  logic [DATA_W-1:0] sv_d;
  logic [DATA_W-1:0] sv_q;

  // Every index value addresses a defined entry, so the read never yields X.
  always_comb begin
    sv_d = rom[v];
  end

  // NOTE: the table is constant and needs no reset; only the output register
  // is cleared, which keeps the array inferable as ROM/LUTs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment, so any logic reading sv_q on this edge
    // sees the value it held before the edge.
    if (rst) sv_q <= '0;
    else     sv_q <= sv_d;
  end

  assign sv = sv_q;

endmodule

// File: tb/tb_sine_lut.sv
// -----------------------------------------------------------------------------
// tb_sine_lut
//   Scoreboard bench for sine_lut. Each driven cycle pushes its expected output,
//   which comes from a real-valued golden model or 0 under reset. The entry is
//   popped and compared one edge later. Inputs change on the falling edge, and
//   outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sine_lut;

  localparam int  ADDR_W = 13;
  localparam int  DATA_W = 16;
  localparam real PI     = 3.14159265358979323846;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] v;
  logic [DATA_W-1:0] sv;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  sine_lut #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .AMPL  (32767)
  ) dut (
    .clk(clk),
    .rst(rst),
    .v  (v),
    .sv (sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model: round_half_up(32767 * sin(pi * idx / 16384)).
  function automatic int golden(input int idx);
    real a;
    a = 32767.0 * $sin(PI * real'(idx) / 16384.0);
    return $rtoi($floor(a + 0.5));
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle, records the expectation, and compares after the edge.
  task automatic step(input logic r, input logic [ADDR_W-1:0] val, input string tag);
    int expected;
    @(negedge clk);
    rst = r;
    v   = val;
    exp_q.push_back(r ? 0 : golden(int'(val)));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      expected = exp_q.pop_front();
      check(tag, int'(sv), expected);
    end
  endtask

  initial begin : stim
    int mono_bad;
    int msb_bad;
    int prev;
    logic [ADDR_W-1:0] inv;
    int key_v   [5] = '{0, 2048, 4096, 6144, 8191};
    int key_exp [5] = '{0, 12539, 23170, 30273, 32767};

    rst = 1'b1;
    v   = 13'd4096;

    // Reset held for 3 cycles with a non-zero index applied.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 13'd4096, "reset_hold");
      check("reset_hold_zero", int'(sv), 0);
    end
    step(1'b0, 13'd4096, "reset_release");
    check("reset_release_const", int'(sv), 23170);

    // Key points on consecutive cycles, checked against fixed constants.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, ADDR_W'(key_v[i]), "key_model");
      check($sformatf("key_%0d", key_v[i]), int'(sv), key_exp[i]);
    end

    // Full sweep with monotonicity and sign-bit tracking.
    mono_bad = 0;
    msb_bad  = 0;
    prev     = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      step(1'b0, ADDR_W'(i), $sformatf("sweep_%0d", i));
      if (int'(sv) < prev) mono_bad++;
      if (sv[DATA_W-1])    msb_bad++;
      prev = int'(sv);
    end
    check("sweep_monotonic_violations", mono_bad, 0);
    check("sweep_msb_set_count", msb_bad, 0);

    // Fold symmetry: an index and its bitwise inverse.
    inv = ~13'd100;
    step(1'b0, 13'd100, "fold_100");
    step(1'b0, inv, "fold_inv_100");

    // Reset mid-stream: the lookup sampled with rst high is discarded.
    step(1'b0, 13'd8191, "mid_pre");
    step(1'b1, 13'd8191, "mid_rst");
    check("mid_rst_zero", int'(sv), 0);
    step(1'b0, 13'd1, "mid_release_v1");

    // Hold: constant index, output stable at several points within the cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 13'd4096, "hold");
      #3;
      check("hold_midcycle", int'(sv), 23170);
    end

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
